flippy_column_array: RTL and testbench

Parametrised game-logic engine for FlippyBit: manages `NUM_COLS` independently falling letter columns instead of one. It owns the fall timer, the staggered spawning of new letters from an internal LFSR, the matching of the player's switch value against every active column, scoring, and game-over detection. Packed `letters`/`ypos` outputs feed the `Display` renderer directly, one slot per column.

---
 rtl/flippy_column_array.sv | 133 +++++++++++++
 tb/tb_flippy_column_array.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flippy_column_array.sv
// FlippyBit game engine: several independently falling letter columns with LFSR spawning,
// guess matching, saturating score and sticky game-over detection.
module flippy_column_array #(
  parameter int unsigned NUM_COLS  = 3,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ROWS      = 22,
  parameter int unsigned ROW_W     = 5,
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned SPAWN_GAP = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clock,
  input  logic                       reset_signal,
  input  logic [DATA_W-1:0]          user_input,
  input  logic                       submit,
  output logic [NUM_COLS*DATA_W-1:0] letters,
  output logic [NUM_COLS*ROW_W-1:0]  ypos,
  output logic [NUM_COLS-1:0]        active,
  output logic                       correct,
  output logic                       miss,
  output logic [15:0]                score,
  output logic                       game_over
);
  localparam int unsigned TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int unsigned SPAWN_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_GAP - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);

  logic [15:0]         lfsr;
  logic [TICK_W-1:0]   tick_cnt;
  logic [SPAWN_W-1:0]  spawn_cnt;
  logic                submit_q;

  logic                tick;
  logic                guess;
  logic                hit;
  logic                overflow;
  logic                free_found;
  logic [ROW_W-1:0]    best_y;
  logic [NUM_COLS-1:0] clear_mask;
  logic [NUM_COLS-1:0] moving;
  logic [NUM_COLS-1:0] spawn_mask;

  always_comb begin
    tick       = (tick_cnt == TICK_LAST);
    guess      = submit & ~submit_q & ~game_over;
    hit        = 1'b0;
    best_y     = '0;
    clear_mask = '0;
    // Strictly-greater compare in ascending order keeps the lowest index on ypos ties.
    if (guess) begin
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        if (active[c] && (letters[c*DATA_W +: DATA_W] == user_input) &&
            (!hit || (ypos[c*ROW_W +: ROW_W] > best_y))) begin
          hit           = 1'b1;
          best_y        = ypos[c*ROW_W +: ROW_W];
          clear_mask    = '0;
          clear_mask[c] = 1'b1;
        end
      end
    end

    moving   = active & ~clear_mask;
    overflow = 1'b0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (moving[c] && (ypos[c*ROW_W +: ROW_W] == ROW_LAST)) overflow = 1'b1;
    end

    // Free slot is judged on the start-of-cycle state, so a column cleared now is not reused.
    spawn_mask = '0;
    free_found = 1'b0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (!active[c] && !free_found) begin
        spawn_mask[c] = 1'b1;
        free_found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      lfsr      <= LFSR_SEED;
      tick_cnt  <= '0;
      spawn_cnt <= SPAWN_LAST;
      submit_q  <= 1'b0;
      letters   <= '0;
      ypos      <= '0;
      active    <= '0;
      correct   <= 1'b0;
      miss      <= 1'b0;
      score     <= '0;
      game_over <= 1'b0;
    end else begin
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      submit_q <= submit;
      correct  <= hit;
      miss     <= guess & ~hit;
      if (!game_over) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (hit && (score != '1)) score <= score + 1'b1;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
          if (clear_mask[c]) begin
            active[c]                    <= 1'b0;
            ypos[c*ROW_W +: ROW_W]       <= '0;
            letters[c*DATA_W +: DATA_W]  <= '0;
          end
        end
        if (tick) begin
          if (overflow) begin
            game_over <= 1'b1;
          end else begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
              if (moving[c]) ypos[c*ROW_W +: ROW_W] <= ypos[c*ROW_W +: ROW_W] + 1'b1;
            end
            if (spawn_cnt == SPAWN_LAST) begin
              spawn_cnt <= '0;
              for (int unsigned c = 0; c < NUM_COLS; c++) begin
                if (spawn_mask[c]) begin
                  active[c]                   <= 1'b1;
                  ypos[c*ROW_W +: ROW_W]      <= '0;
                  letters[c*DATA_W +: DATA_W] <= lfsr[DATA_W-1:0];
                end
              end
            end else begin
              spawn_cnt <= spawn_cnt + 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_flippy_column_array.sv
// Scoreboard bench for flippy_column_array: a behavioural game model predicts every cycle's outputs.
module tb_flippy_column_array;
  localparam int unsigned NC   = 2;
  localparam int unsigned DW   = 8;
  localparam int unsigned ROWS = 4;
  localparam int unsigned RW   = 2;
  localparam int unsigned TD   = 4;
  localparam int unsigned SG   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic             clock = 1'b0;
  logic             reset_signal = 1'b1;
  logic [DW-1:0]    user_input = '0;
  logic             submit = 1'b0;
  logic [NC*DW-1:0] letters;
  logic [NC*RW-1:0] ypos;
  logic [NC-1:0]    active;
  logic             correct;
  logic             miss;
  logic [15:0]      score;
  logic             game_over;

  flippy_column_array #(
    .NUM_COLS(NC), .DATA_W(DW), .ROWS(ROWS), .ROW_W(RW),
    .TICK_DIV(TD), .SPAWN_GAP(SG), .LFSR_SEED(SEED)
  ) dut (
    .clock(clock), .reset_signal(reset_signal), .user_input(user_input), .submit(submit),
    .letters(letters), .ypos(ypos), .active(active), .correct(correct), .miss(miss),
    .score(score), .game_over(game_over)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NC*DW-1:0] letters;
    logic [NC*RW-1:0] ypos;
    logic [NC-1:0]    active;
    logic             correct;
    logic             miss;
    logic [15:0]      score;
    logic             game_over;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [15:0]   m_lfsr;
  logic [DW-1:0] m_let[NC];
  logic [RW-1:0] m_y[NC];
  logic [NC-1:0] m_act;
  logic          m_corr, m_miss, m_go, m_subq;
  logic [15:0]   m_score;
  int            m_tcnt, m_scnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_act = '0; m_corr = 0; m_miss = 0; m_go = 0; m_subq = 0;
    m_score = '0; m_tcnt = 0; m_scnt = SG - 1;
    for (int c = 0; c < NC; c++) begin m_let[c] = '0; m_y[c] = '0; end
  endtask

  task automatic model_step();
    logic [NC-1:0] act0;
    int win;
    logic ovf;
    logic [15:0] nl;
    nl = lfsr_adv(m_lfsr);
    if (reset_signal) begin model_reset(); return; end
    m_corr = 0; m_miss = 0;
    act0 = m_act;
    win = -1;
    if (!m_go) begin
      if (submit && !m_subq) begin
        for (int c = NC - 1; c >= 0; c--)
          if (act0[c] && m_let[c] == user_input && (win < 0 || m_y[c] >= m_y[win])) win = c;
        if (win >= 0) begin
          m_corr = 1; m_act[win] = 0; m_y[win] = '0; m_let[win] = '0;
          if (m_score != 16'hFFFF) m_score++;
        end else m_miss = 1;
      end
      if (m_tcnt == TD - 1) begin
        m_tcnt = 0;
        ovf = 0;
        for (int c = 0; c < NC; c++) if (act0[c] && c != win && m_y[c] == ROWS - 1) ovf = 1;
        if (ovf) m_go = 1;
        else begin
          for (int c = 0; c < NC; c++) if (act0[c] && c != win) m_y[c] = m_y[c] + 1'b1;
          if (m_scnt == SG - 1) begin
            m_scnt = 0;
            for (int c = 0; c < NC; c++)
              if (!act0[c]) begin
                m_act[c] = 1; m_y[c] = '0; m_let[c] = m_lfsr[DW-1:0];
                break;
              end
          end else m_scnt++;
        end
      end else m_tcnt++;
    end
    m_subq = submit;
    m_lfsr = nl;
  endtask

  function automatic exp_t snapshot();
    exp_t s;
    for (int c = 0; c < NC; c++) begin
      s.letters[c*DW +: DW] = m_let[c];
      s.ypos[c*RW +: RW]    = m_y[c];
    end
    s.active = m_act; s.correct = m_corr; s.miss = m_miss;
    s.score = m_score; s.game_over = m_go;
    return s;
  endfunction

  task automatic cycle();
    exp_t e;
    model_step();
    sb_q.push_back(snapshot());
    @(posedge clock); #1;
    e = sb_q.pop_front();
    check_val("sb_letters", letters, e.letters);
    check_val("sb_ypos", ypos, e.ypos);
    check_val("sb_active", active, e.active);
    check_val("sb_correct", correct, e.correct);
    check_val("sb_miss", miss, e.miss);
    check_val("sb_score", score, e.score);
    check_val("sb_game_over", game_over, e.game_over);
  endtask

  // Called at posedge+1 just after reset has been released.
  task automatic spawn_check(input string pfx);
    logic [15:0] r;
    r = SEED;
    repeat (3) r = lfsr_adv(r);
    repeat (4) cycle();
    check_val({pfx, "_spawn_active"}, active, 2'b01);
    check_val({pfx, "_spawn_ypos0"}, ypos[RW-1:0], 0);
    check_val({pfx, "_spawn_letter"}, letters[DW-1:0], r[DW-1:0]);
    check_val({pfx, "_spawn_score"}, score, 0);
    repeat (8) cycle();
    check_val({pfx, "_grow_active"}, active, 2'b11);
    check_val({pfx, "_grow_ypos0"}, ypos[RW-1:0], 2);
    check_val({pfx, "_grow_ypos1"}, ypos[2*RW-1:RW], 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pick;
    exp_t fr;
    logic [RW-1:0] y1;

    model_reset();
    repeat (3) cycle();
    reset_signal = 1'b0;
    spawn_check("first");

    // Match on column 0
    user_input = m_let[0];
    submit = 1'b1;
    cycle();
    check_val("match_correct", correct, 1);
    check_val("match_active0", active[0], 0);
    check_val("match_score", score, 1);
    submit = 1'b0;
    cycle();
    check_val("match_correct_drop", correct, 0);

    // Held non-matching strobe
    user_input = m_let[1] ^ 8'hFF;
    submit = 1'b1;
    n = 0;
    repeat (10) begin cycle(); if (miss === 1'b1) n++; end
    submit = 1'b0;
    check_val("held_miss_count", n, 1);
    check_val("held_score", score, 1);

    // Let the columns fall to game over
    n = 0;
    while (!m_go && n < 200) begin cycle(); n++; end
    check_val("go_set", game_over, 1);
    fr = snapshot();
    repeat (40) cycle();
    check_val("go_frozen_ypos", ypos, fr.ypos);
    check_val("go_frozen_active", active, fr.active);
    pick = m_act[0] ? 0 : 1;
    user_input = m_let[pick];
    submit = 1'b1;
    cycle();
    check_val("go_no_correct", correct, 0);
    check_val("go_no_miss", miss, 0);
    submit = 1'b0;
    cycle();

    // Coincident clear and tick with column 0 on the last row
    reset_signal = 1'b1;
    cycle();
    reset_signal = 1'b0;
    n = 0;
    while (!(m_tcnt == TD - 1 && m_act[0] && m_y[0] == ROWS - 1) && n < 100) begin cycle(); n++; end
    y1 = m_y[1] + 1'b1;
    user_input = m_let[0];
    submit = 1'b1;
    cycle();
    submit = 1'b0;
    check_val("coin_correct", correct, 1);
    check_val("coin_active0", active[0], 0);
    check_val("coin_game_over", game_over, 0);
    check_val("coin_ypos1", ypos[2*RW-1:RW], y1);

    // Build score 3 with both columns live, clearing the lowest column each time
    n = 0;
    while ((m_score < 3 || m_act != 2'b11) && !m_go && n < 200) begin
      if (m_score < 3 && !submit && m_act != 2'b00) begin
        pick = (m_act[1] && (!m_act[0] || m_y[1] > m_y[0])) ? 1 : 0;
        user_input = m_let[pick];
        submit = 1'b1;
      end else submit = 1'b0;
      cycle();
      n++;
    end
    submit = 1'b0;
    check_val("pre_reset_score", score, 3);
    check_val("pre_reset_active", active, 2'b11);

    // Asynchronous reset between edges
    #3;
    reset_signal = 1'b1;
    #1;
    check_val("async_letters", letters, 0);
    check_val("async_ypos", ypos, 0);
    check_val("async_active", active, 0);
    check_val("async_correct", correct, 0);
    check_val("async_miss", miss, 0);
    check_val("async_score", score, 0);
    check_val("async_game_over", game_over, 0);
    model_reset();
    cycle();
    reset_signal = 1'b0;
    spawn_check("respawn");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
